// File: rtl/seg_bcd_reader.sv
// Recovers BCD digits from a multiplexed active-high 7-segment bus and presents whole frames via valid/ready.
// Define SEG_READER_BLANK_EN to decode an all-off digit as a blank (4'hF, no error) instead of an error.
module seg_bcd_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frm_valid,
    input  logic                    frm_ready,
    output logic [4*NUM_DIGITS-1:0] frm_bcd,
    output logic [NUM_DIGITS-1:0]   frm_err,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t                  state;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic [6:0]              seg_l;
    logic [NUM_DIGITS-1:0]   dig_l;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_DIGITS-1:0]   seen;
    logic [3:0]              bank_bcd [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   bank_err;

    logic [3:0]              dec_bcd;
    logic                    dec_err;
    logic                    q_onehot;
    logic                    q_same;
    logic                    capture;
    logic                    complete;

    assign q_onehot = (dig_q != '0) && ((dig_q & (dig_q - DIG_ONE)) == '0);
    assign q_same   = (seg_q == seg_l) && (dig_q == dig_l);
    // The incoming identical sample is the STABLE_CYCLES-th one, so capture on this edge.
    assign capture  = (state == SETTLE) && q_same && (cnt >= CNT_LAST);
    assign complete = &seen;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        dec_bcd = 4'h0;
        dec_err = 1'b0;
        case (seg_l)
            7'b1111110: dec_bcd = 4'd0;
            7'b0110000: dec_bcd = 4'd1;
            7'b1101101: dec_bcd = 4'd2;
            7'b1111001: dec_bcd = 4'd3;
            7'b0110011: dec_bcd = 4'd4;
            7'b1011011: dec_bcd = 4'd5;
            7'b1011111: dec_bcd = 4'd6;
            7'b1110000: dec_bcd = 4'd7;
            7'b1111111: dec_bcd = 4'd8;
            7'b1111011: dec_bcd = 4'd9;
`ifdef SEG_READER_BLANK_EN
            7'b0000000: dec_bcd = 4'hF;
`endif
            default:    dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every block sees the pre-edge values.
        if (rst) begin
            state <= IDLE;
            seg_q <= '0;
            dig_q <= '0;
            seg_l <= '0;
            dig_l <= '0;
            cnt   <= '0;
        end else begin
            seg_q <= seg;
            dig_q <= dig_en;
            if (state == IDLE || !q_same) begin
                if (q_onehot) begin
                    state <= SETTLE;
                    cnt   <= CNT_ONE;
                    seg_l <= seg_q;
                    dig_l <= dig_q;
                end else begin
                    state <= IDLE;
                end
            end else if (state == SETTLE) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
                if (capture) begin
                    state <= HOLD;
                end
            end
        end
    end

    // NOTE: the working bank is not reset; seen gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_l[i]) begin
                    bank_bcd[i] <= dec_bcd;
                    bank_err[i] <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen      <= '0;
            frm_valid <= 1'b0;
            frm_bcd   <= '0;
            frm_err   <= '0;
            overrun   <= 1'b0;
        end else if (complete) begin
            seen <= capture ? dig_l : '0;
            if (!frm_valid || frm_ready) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    frm_bcd[4*i +: 4] <= bank_bcd[i];
                end
                frm_err   <= bank_err;
                frm_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else begin
            if (capture) begin
                seen <= seen | dig_l;
            end
            if (frm_valid && frm_ready) begin
                frm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_bcd_reader.sv
// Self-checking bench for seg_bcd_reader: directed scenarios plus randomized scans against a
// cycle-level run-length reference model.
module tb_seg_bcd_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg = '0;
    logic [ND-1:0]   dig_en = '0;
    logic            frm_valid;
    logic            frm_ready = 1'b1;
    logic [4*ND-1:0] frm_bcd;
    logic [ND-1:0]   frm_err;
    logic            overrun;

    int total = 0;
    int bad   = 0;

    seg_bcd_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .dig_en   (dig_en),
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .frm_bcd  (frm_bcd),
        .frm_err  (frm_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    typedef struct {
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   err;
    } frame_t;

    // Reference model: a digit is taken once a pin value has been identical for SC cycles.
    logic [6:0]    m_seg;
    logic [ND-1:0] m_dig;
    int            m_run = 0;
    logic [3:0]    m_bcd [ND];
    logic [ND-1:0] m_err = '0;
    logic [ND-1:0] m_seen = '0;
    logic          m_overrun = 1'b0;
    int            m_frames = 0;
    frame_t        exp_q [$];

    int              frames_rx = 0;
    logic [4*ND-1:0] last_bcd = '0;
    logic [ND-1:0]   last_err = '0;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        logic [4:0] r;
        r = {1'b1, 4'h0};
        for (int i = 0; i < 10; i++) begin
            if (s == pat[i]) r = {1'b0, 4'(i)};
        end
`ifdef SEG_READER_BLANK_EN
        if (s == 7'b0000000) r = {1'b0, 4'hF};
`endif
        return r;
    endfunction

    task automatic model_cycle(input logic [6:0] s, input logic [ND-1:0] d);
        frame_t     f;
        logic [4:0] r;
        if (m_run > 0 && s == m_seg && d == m_dig) begin
            if (m_run <= SC) m_run++;
        end else begin
            m_run = 1;
        end
        m_seg = s;
        m_dig = d;
        if ($countones(d) == 1 && m_run == SC) begin
            for (int k = 0; k < ND; k++) begin
                if (d[k]) begin
                    r        = ref_decode(s);
                    m_bcd[k] = r[3:0];
                    m_err[k] = r[4];
                end
            end
            m_seen = m_seen | d;
            if (&m_seen) begin
                for (int k = 0; k < ND; k++) f.bcd[4*k +: 4] = m_bcd[k];
                f.err = m_err;
                if (exp_q.size() > 0) m_overrun = 1'b1;
                else begin
                    exp_q.push_back(f);
                    m_frames++;
                end
                m_seen = '0;
            end
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [ND-1:0] d, input int n);
        for (int c = 0; c < n; c++) begin
            seg    = s;
            dig_en = d;
            model_cycle(s, d);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [4*ND-1:0] digits, input int n);
        for (int k = 0; k < ND; k++) drive(pat[digits[4*k +: 4]], ND'(1) << k, n);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        seg    = '0;
        dig_en = '0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        m_run     = 0;
        m_seen    = '0;
        m_overrun = 1'b0;
        exp_q.delete();
    endtask

    // Every accepted frame is checked against the oldest frame the model expects.
    always @(negedge clk) begin
        frame_t f;
        if (!rst && frm_valid && frm_ready) begin
            frames_rx++;
            last_bcd = frm_bcd;
            last_err = frm_err;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame_unexpected: got bcd=%h err=%b, expected no frame", frm_bcd, frm_err);
            end else begin
                f = exp_q.pop_front();
                if (frm_bcd !== f.bcd || frm_err !== f.err) begin
                    bad++;
                    $display("FAIL frame_data: got bcd=%h err=%b, expected bcd=%h err=%b",
                             frm_bcd, frm_err, f.bcd, f.err);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        total += 4;
        if (frm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", frm_valid); end
        if (frm_bcd !== '0) begin bad++; $display("FAIL reset_bcd: got %h expected 0", frm_bcd); end
        if (frm_err !== '0) begin bad++; $display("FAIL reset_err: got %b expected 0", frm_err); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_basic();
        int n0 = frames_rx;
        drive(pat[1], 4'b0001, 6);
        drive(pat[2], 4'b0010, 6);
        drive(pat[3], 4'b0100, 6);
        for (int c = 1; c <= 6; c++) begin
            seg    = pat[4];
            dig_en = 4'b1000;
            model_cycle(pat[4], 4'b1000);
            @(posedge clk);
            #1;
            total++;
            if (frm_valid !== (c == SC + 2)) begin
                bad++;
                $display("FAIL latency c=%0d: got valid=%b expected %b", c, frm_valid, (c == SC + 2));
            end
        end
        drive('0, '0, 4);
        total += 3;
        if (frames_rx - n0 != 1) begin bad++; $display("FAIL basic_count: got %0d expected 1", frames_rx - n0); end
        if (last_bcd !== 16'h4321) begin bad++; $display("FAIL basic_bcd: got %h expected 4321", last_bcd); end
        if (last_err !== 4'b0000) begin bad++; $display("FAIL basic_err: got %b expected 0000", last_err); end
    endtask

    task automatic test_short_hold();
        int n0 = frames_rx;
        repeat (3) scan(16'h4321, SC - 1);
        drive('0, '0, 8);
        total += 2;
        if (frames_rx != n0) begin bad++; $display("FAIL short_count: got %0d expected 0", frames_rx - n0); end
        if (frm_valid !== 1'b0) begin bad++; $display("FAIL short_valid: got %b expected 0", frm_valid); end
    endtask

    task automatic test_non_onehot();
        int n0 = frames_rx;
        drive(pat[1], 4'b0001, 6);
        drive(pat[2], 4'b0010, 6);
        drive(7'h7F, 4'b0011, 20);
        drive(pat[3], 4'b0100, 6);
        drive(pat[4], 4'b1000, 6);
        drive('0, '0, 4);
        total += 3;
        if (frames_rx - n0 != 1) begin bad++; $display("FAIL nonhot_count: got %0d expected 1", frames_rx - n0); end
        if (last_bcd !== 16'h4321) begin bad++; $display("FAIL nonhot_bcd: got %h expected 4321", last_bcd); end
        if (last_err !== 4'b0000) begin bad++; $display("FAIL nonhot_err: got %b expected 0000", last_err); end
    endtask

    task automatic test_invalid();
        int n0 = frames_rx;
        logic [15:0] blank_bcd;
        logic [3:0]  blank_err;
        drive(pat[1], 4'b0001, 6);
        drive(pat[2], 4'b0010, 6);
        drive(7'b1000001, 4'b0100, 6);
        drive(pat[4], 4'b1000, 6);
        drive('0, '0, 4);
        total += 3;
        if (frames_rx - n0 != 1) begin bad++; $display("FAIL invalid_count: got %0d expected 1", frames_rx - n0); end
        if (last_bcd !== 16'h4021) begin bad++; $display("FAIL invalid_bcd: got %h expected 4021", last_bcd); end
        if (last_err !== 4'b0100) begin bad++; $display("FAIL invalid_err: got %b expected 0100", last_err); end
`ifdef SEG_READER_BLANK_EN
        blank_bcd = 16'h4F21;
        blank_err = 4'b0000;
`else
        blank_bcd = 16'h4021;
        blank_err = 4'b0100;
`endif
        n0 = frames_rx;
        drive(pat[1], 4'b0001, 6);
        drive(pat[2], 4'b0010, 6);
        drive(7'b0000000, 4'b0100, 6);
        drive(pat[4], 4'b1000, 6);
        drive('0, '0, 4);
        total += 3;
        if (frames_rx - n0 != 1) begin bad++; $display("FAIL blank_count: got %0d expected 1", frames_rx - n0); end
        if (last_bcd !== blank_bcd) begin bad++; $display("FAIL blank_bcd: got %h expected %h", last_bcd, blank_bcd); end
        if (last_err !== blank_err) begin bad++; $display("FAIL blank_err: got %b expected %b", last_err, blank_err); end
    endtask

    task automatic test_random();
        int         n0 = frames_rx;
        int         mf0 = m_frames;
        int         order [ND];
        int         j, t;
        logic [6:0] s;
        for (int fr = 0; fr < 10; fr++) begin
            for (int k = 0; k < ND; k++) order[k] = k;
            for (int k = ND - 1; k > 0; k--) begin
                j        = $urandom_range(0, k);
                t        = order[k];
                order[k] = order[j];
                order[j] = t;
            end
            for (int k = 0; k < ND; k++) begin
                if ($urandom_range(0, 2) == 0) drive(7'($urandom), ND'($urandom), $urandom_range(1, SC - 1));
                if ($urandom_range(0, 7) == 0) s = 7'($urandom);
                else s = pat[$urandom_range(0, 9)];
                drive(s, ND'(1) << order[k], $urandom_range(SC, SC + 3));
                if (k < ND - 1 && $urandom_range(0, 3) == 0)
                    drive(pat[$urandom_range(0, 9)], ND'(1) << order[k], $urandom_range(SC, SC + 3));
            end
        end
        drive('0, '0, 6);
        total += 3;
        if (frames_rx - n0 != m_frames - mf0) begin
            bad++;
            $display("FAIL random_count: got %0d expected %0d", frames_rx - n0, m_frames - mf0);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL random_pending: got %0d expected 0", exp_q.size()); end
        if (overrun !== m_overrun) begin bad++; $display("FAIL random_overrun: got %b expected %b", overrun, m_overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        frm_ready = 1'b0;
        scan(16'h8765, 6);
        drive('0, '0, 4);
        total += 3;
        if (frm_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_a: got %b expected 1", frm_valid); end
        if (frm_bcd !== 16'h8765) begin bad++; $display("FAIL b2b_bcd_a: got %h expected 8765", frm_bcd); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun_a: got %b expected 0", overrun); end
        scan(16'h2109, 6);
        drive('0, '0, 4);
        total += 3;
        if (frm_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_b: got %b expected 1", frm_valid); end
        if (frm_bcd !== 16'h8765) begin bad++; $display("FAIL b2b_bcd_held: got %h expected 8765", frm_bcd); end
        if (overrun !== m_overrun) begin bad++; $display("FAIL b2b_overrun_b: got %b expected %b", overrun, m_overrun); end
        frm_ready = 1'b1;
        drive('0, '0, 1);
        total += 3;
        if (frm_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %b expected 0", frm_valid); end
        if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_sticky: got %b expected 1", overrun); end
        if (last_bcd !== 16'h8765) begin bad++; $display("FAIL b2b_accepted: got %h expected 8765", last_bcd); end
    endtask

    task automatic test_reset_mid();
        int n0;
        frm_ready = 1'b1;
        drive(pat[1], 4'b0001, 6);
        drive(pat[2], 4'b0010, 6);
        drive(pat[3], 4'b0100, 6);
        do_reset();
        total += 4;
        if (frm_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b expected 0", frm_valid); end
        if (frm_bcd !== '0) begin bad++; $display("FAIL mid_bcd: got %h expected 0", frm_bcd); end
        if (frm_err !== '0) begin bad++; $display("FAIL mid_err: got %b expected 0", frm_err); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
        n0 = frames_rx;
        drive(pat[4], 4'b1000, 6);
        drive('0, '0, 4);
        total++;
        if (frames_rx != n0) begin bad++; $display("FAIL mid_partial: got %0d frames expected 0", frames_rx - n0); end
        scan(16'h4321, 6);
        drive('0, '0, 6);
        total += 2;
        if (frames_rx - n0 != 1) begin bad++; $display("FAIL mid_count: got %0d expected 1", frames_rx - n0); end
        if (last_bcd !== 16'h4321) begin bad++; $display("FAIL mid_frame: got %h expected 4321", last_bcd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_hold();
        test_non_onehot();
        test_invalid();
        test_random();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL final_pending: got %0d expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
